parser_copy_fifo_param: RTL and testbench
=========================================

// Module: parser_copy_fifo_param
// PURPOSE
//  Parametrised synchronous FIFO that buffers copy tokens from the parser to the copy engine.
//  Generalises the fixed 8x33 parser-copy FIFO:
//  - power-of-two depth; programmable prog_full threshold
//  - optional first-word-fall-through (FWFT) read mode
//  - occupancy count, sticky overflow/underflow flags, reset-busy handshake
// PARAMETERS
//  WIDTH        33  data word width in bits
//  DEPTH        8   number of entries; power of two, >=4
//  PROG_FULL_TH 3   prog_full asserts when count >= this value; 1..DEPTH
//  FWFT         0   0 = standard read (1-cycle latency); 1 = first-word-fall-through
//  AW           $clog2(DEPTH)  local param: pointer width; count is AW+1 bits
// PORTS
//  clk          in   1       single clock; all logic on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  din          in   WIDTH   write data
//  wr_en        in   1       write request
//  full         out  1       count == DEPTH
//  prog_full    out  1       count >= PROG_FULL_TH
//  rd_en        in   1       read request (FWFT: pop/acknowledge of dout)
//  dout         out  WIDTH   read data
//  valid        out  1       dout holds a valid word
//  empty        out  1       no word available to the read side (see FWFT)
//  count        out  AW+1    stored entries, excluding the FWFT output register
//  overflow     out  1       sticky: wr_en while full or busy; cleared only by reset
//  underflow    out  1       sticky: rd_en while empty or busy; cleared only by reset
//  wr_rst_busy  out  1       write side not ready
//  rd_rst_busy  out  1       read side not ready
// BEHAVIOUR
//  Reset (rst_n low, asynchronous):
//  - pointers, count, dout, valid, overflow and underflow are 0
//  - empty = 1, full = 0, prog_full = 0, wr_rst_busy = rd_rst_busy = 1
//  Busy release:
//  - busy flags stay 1 for 2 clk cycles after rst_n rises (2-bit counter), then drop together
//  - while busy, wr_en and rd_en are ignored and flagged as overflow/underflow
//  Write accepted iff wr_en & !full & !busy:
//  - ram[wr_ptr] <= din; wr_ptr increments mod DEPTH (natural AW-bit wrap)
//  - full always blocks the write, even when a read occurs in the same cycle
//  FWFT=0 read accepted iff rd_en & !empty & !busy:
//  - dout <= ram[rd_ptr] on the next edge; valid is 1 for exactly that cycle
//  - dout holds its last value otherwise
//  - empty = (count == 0)
//  FWFT=1:
//  - output register autoloads from RAM when it is unoccupied or popped (rd_en & valid) and count > 0
//  - first word after an empty state: valid rises 1 cycle after the accepted write
//  - empty = !valid; rd_en & valid pops the word; back-to-back pops sustain 1 word/cycle
//  Count:
//  - +1 on an accepted write, -1 on a RAM read
//  - simultaneous write and RAM read leave count unchanged
//  - no wrap: full and empty gating keep count in 0..DEPTH
//  Simultaneous events:
//  - wr and rd at count==0 (FWFT=0): write accepted, read rejected -> underflow
//  - wr and rd at count==DEPTH: read accepted, write rejected -> overflow
//  Flags are registered from next-state count, so full/prog_full/empty are exact in the cycle after the update.
//  Reset mid-operation discards all contents immediately; RAM contents are don't-care.
// TESTING
//  T1 reset: rst_n=0 mid-stream -> empty=1, count=0, valid=0, busy=1; busy clears 2 cycles after release
//  T2 fill (FWFT=0, DEPTH=8): 8 writes 0x1..0x8 -> full=1, count=8, prog_full from 3rd write;
//     9th write -> overflow=1, count stays 8
//  T3 drain: 8 reads -> dout 0x1..0x8, each 1 cycle after rd_en, valid pulses;
//     extra read -> underflow=1, dout holds 0x8
//  T4 wrap: write 5, read 5, repeated 4 times (pointers wrap) -> data order preserved, count 0 at end
//  T5 simultaneous rd+wr at count=4 for 20 cycles -> count stays 4, full/empty never toggle;
//     same at count=8 -> write rejected, overflow=1
//  T6 FWFT=1, DEPTH=16, PROG_FULL_TH=12: single write 0xAB -> valid=1, dout=0xAB next cycle;
//     continuous pops at 1/cycle stream without bubbles

Source files
------------

// File: rtl/parser_copy_fifo_param.sv
// rtl/parser_copy_fifo_param.sv - parametrised parser-to-copy-engine token FIFO
// Power-of-two depth, prog_full threshold, optional FWFT output register, sticky error flags.
module parser_copy_fifo_param #(
  parameter int WIDTH        = 33,
  parameter int DEPTH        = 8,
  parameter int PROG_FULL_TH = 3,
  parameter int FWFT         = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           din,
  input  logic                       wr_en,
  output logic                       full,
  output logic                       prog_full,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       wr_rst_busy,
  output logic                       rd_rst_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] PF_TH   = (AW+1)'(PROG_FULL_TH);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [1:0]       busy_cnt;
  logic             busy;

  logic             wr_ok;
  logic             ram_rd;
  logic             pop;
  logic             valid_nxt;
  logic [AW:0]      count_nxt;

  assign wr_rst_busy = busy;
  assign rd_rst_busy = busy;

  // In FWFT mode the output register refills itself whenever it is free or being popped.
  always_comb begin
    wr_ok     = wr_en & ~full & ~busy;
    pop       = 1'b0;
    ram_rd    = 1'b0;
    valid_nxt = 1'b0;
    if (FWFT != 0) begin
      pop       = rd_en & valid & ~busy;
      ram_rd    = (~valid | pop) & (count != '0) & ~busy;
      valid_nxt = ram_rd | (valid & ~pop);
    end else begin
      ram_rd    = rd_en & ~empty & ~busy;
      valid_nxt = ram_rd;
    end
    count_nxt = count + (AW+1)'(wr_ok) - (AW+1)'(ram_rd);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      ram[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      empty     <= 1'b1;
      full      <= 1'b0;
      prog_full <= 1'b0;
      busy_cnt  <= 2'd0;
      busy      <= 1'b1;
    end else begin
      if (busy) begin
        busy_cnt <= busy_cnt + 2'd1;
        if (busy_cnt == 2'd1) begin
          busy <= 1'b0;
        end
      end
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (ram_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= ram[rd_ptr];
      end
      valid     <= valid_nxt;
      count     <= count_nxt;
      // Flags come from the next-state count so they are exact right after the update.
      full      <= (count_nxt == DEPTH_C);
      prog_full <= (count_nxt >= PF_TH);
      empty     <= (FWFT != 0) ? ~valid_nxt : (count_nxt == '0);
      overflow  <= overflow  | (wr_en & (full  | busy));
      underflow <= underflow | (rd_en & (empty | busy));
    end
  end

endmodule

// File: tb/tb_parser_copy_fifo_param.sv
// tb/tb_parser_copy_fifo_param.sv - scoreboard bench for parser_copy_fifo_param
module tb_parser_copy_fifo_param;

  logic        clk;
  logic        rst_n;

  logic [32:0] din_a, dout_a;
  logic        wr_a, rd_a, full_a, pfull_a, valid_a, empty_a, ovf_a, unf_a, wbusy_a, rbusy_a;
  logic [3:0]  count_a;

  logic [32:0] din_b, dout_b;
  logic        wr_b, rd_b, full_b, pfull_b, valid_b, empty_b, ovf_b, unf_b, wbusy_b, rbusy_b;
  logic [4:0]  count_b;

  int vec_cnt = 0;
  int mis_cnt = 0;

  logic [32:0] qa[$];
  logic [32:0] qb[$];
  int mcount;
  bit movf, munf;

  parser_copy_fifo_param #(.WIDTH(33), .DEPTH(8), .PROG_FULL_TH(3), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .din(din_a), .wr_en(wr_a), .full(full_a), .prog_full(pfull_a),
    .rd_en(rd_a), .dout(dout_a), .valid(valid_a), .empty(empty_a), .count(count_a),
    .overflow(ovf_a), .underflow(unf_a), .wr_rst_busy(wbusy_a), .rd_rst_busy(rbusy_a)
  );

  parser_copy_fifo_param #(.WIDTH(33), .DEPTH(16), .PROG_FULL_TH(12), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .din(din_b), .wr_en(wr_b), .full(full_b), .prog_full(pfull_b),
    .rd_en(rd_b), .dout(dout_b), .valid(valid_b), .empty(empty_b), .count(count_b),
    .overflow(ovf_b), .underflow(unf_b), .wr_rst_busy(wbusy_b), .rd_rst_busy(rbusy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Standard-mode read data is checked against the scoreboard whenever valid is seen.
  always @(negedge clk) begin
    if (rst_n && valid_a) begin
      if (qa.size() == 0) check("a_spurious_valid", valid_a, 1'b0);
      else                check("a_dout", dout_a, qa.pop_front());
    end
  end

  task automatic cyc_a(input bit w, input logic [32:0] d, input bit r);
    bit wa, ra;
    wr_a = w; din_a = d; rd_a = r;
    wa = w && (mcount < 8);
    ra = r && (mcount > 0);
    if (w && !wa) movf = 1'b1;
    if (r && !ra) munf = 1'b1;
    if (wa) qa.push_back(d);
    mcount = mcount + int'(wa) - int'(ra);
    @(posedge clk); #1;
    wr_a = 1'b0; rd_a = 1'b0;
    check("a_count", count_a, mcount);
    check("a_full", full_a, mcount == 8);
    check("a_empty", empty_a, mcount == 0);
    check("a_prog_full", pfull_a, mcount >= 3);
    check("a_valid", valid_a, ra);
    check("a_overflow", ovf_a, movf);
    check("a_underflow", unf_a, munf);
  endtask

  task automatic do_reset(input bit poke);
    rst_n = 1'b0;
    #1;
    qa.delete(); qb.delete();
    mcount = 0; movf = 1'b0; munf = 1'b0;
    check("rst_empty", empty_a, 1'b1);
    check("rst_count", count_a, 0);
    check("rst_valid", valid_a, 1'b0);
    check("rst_full", full_a, 1'b0);
    check("rst_busy", wbusy_a & rbusy_a, 1'b1);
    check("rst_b_empty", empty_b, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    if (poke) begin
      wr_a = 1'b1; rd_a = 1'b1; din_a = 33'h55;
    end
    @(posedge clk); #1;
    wr_a = 1'b0; rd_a = 1'b0;
    check("busy_hold", wbusy_a & rbusy_a, 1'b1);
    check("busy_ovf", ovf_a, poke);
    check("busy_unf", unf_a, poke);
    check("busy_count", count_a, 0);
    @(posedge clk); #1;
    check("busy_release", wbusy_a | rbusy_a | wbusy_b | rbusy_b, 1'b0);
    movf = poke; munf = poke;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr_a = 1'b0; rd_a = 1'b0; din_a = '0;
    wr_b = 1'b0; rd_b = 1'b0; din_b = '0;
    @(posedge clk); #1;
    do_reset(1'b0);

    // fill, overflow, drain, underflow
    for (int i = 1; i <= 8; i++) cyc_a(1'b1, 33'(i), 1'b0);
    cyc_a(1'b1, 33'h9, 1'b0);
    for (int i = 0; i < 8; i++) cyc_a(1'b0, '0, 1'b1);
    cyc_a(1'b0, '0, 1'b1);
    check("a_dout_hold", dout_a, 33'h8);

    // reset mid-stream with a read in flight, then errors during busy
    cyc_a(1'b1, 33'h1_0000_0011, 1'b0);
    cyc_a(1'b1, 33'h22, 1'b0);
    cyc_a(1'b0, '0, 1'b1);
    do_reset(1'b1);
    do_reset(1'b0);

    // pointer wrap
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) cyc_a(1'b1, 33'(r * 16 + i + 'h40), 1'b0);
      for (int i = 0; i < 5; i++) cyc_a(1'b0, '0, 1'b1);
    end
    check("a_wrap_count", count_a, 0);

    // simultaneous read/write at count 4 and at full
    for (int i = 0; i < 4; i++) cyc_a(1'b1, {1'b1, 32'($urandom())}, 1'b0);
    for (int i = 0; i < 20; i++) cyc_a(1'b1, {1'b0, 32'($urandom())}, 1'b1);
    for (int i = 0; i < 4; i++) cyc_a(1'b1, {1'b1, 32'($urandom())}, 1'b0);
    cyc_a(1'b1, 33'h1_dead_beef, 1'b1);
    while (mcount > 0) cyc_a(1'b0, '0, 1'b1);
    cyc_a(1'b0, '0, 1'b0);

    // FWFT: single word falls through one cycle after the write
    wr_b = 1'b1; din_b = 33'hAB;
    @(posedge clk); #1;
    wr_b = 1'b0;
    check("b_count_1", count_b, 1);
    check("b_valid_early", valid_b, 1'b0);
    @(posedge clk); #1;
    check("b_valid", valid_b, 1'b1);
    check("b_dout", dout_b, 33'hAB);
    check("b_empty", empty_b, 1'b0);
    check("b_count_0", count_b, 0);
    rd_b = 1'b1;
    @(posedge clk); #1;
    rd_b = 1'b0;
    check("b_popped", valid_b, 1'b0);
    check("b_empty_after", empty_b, 1'b1);
    check("b_unf_clean", unf_b, 1'b0);

    // FWFT burst then back-to-back pops
    for (int i = 0; i < 14; i++) begin
      wr_b = 1'b1; din_b = 33'(32'h100 + i * 3);
      qb.push_back(din_b);
      @(posedge clk); #1;
    end
    wr_b = 1'b0;
    @(posedge clk); #1;
    check("b_count_13", count_b, 13);
    check("b_prog_full", pfull_b, 1'b1);
    check("b_full", full_b, 1'b0);
    for (int i = 0; i < 14; i++) begin
      rd_b = 1'b1;
      check("b_stream_valid", valid_b, 1'b1);
      check("b_stream_dout", dout_b, qb.pop_front());
      @(posedge clk); #1;
    end
    rd_b = 1'b0;
    check("b_drained_valid", valid_b, 1'b0);
    check("b_drained_empty", empty_b, 1'b1);
    check("b_drained_count", count_b, 0);
    check("b_drained_pfull", pfull_b, 1'b0);
    rd_b = 1'b1;
    @(posedge clk); #1;
    rd_b = 1'b0;
    check("b_underflow", unf_b, 1'b1);
    check("b_overflow", ovf_b, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
